uart_rx_sequencer: RTL and testbench
====================================

# uart_rx_sequencer

UART receive sequencer that sits directly behind the RX majority-3 filter and turns its filtered, idle-high serial stream into parallel bytes. It detects the start-bit edge, counts oversampling clocks to mid-bit, samples the data bits LSB-first, and checks the stop bit. Bytes are delivered through a one-entry valid/ready holding buffer, with frame-error and overrun reporting.

## Interface
- CLKS_PER_BIT, 16, clocks per bit period; legal range ≥ 4. HALF = floor(CLKS_PER_BIT/2).
- DATA_BITS, 8, data bits per frame; legal range 5..9.

- clkIn  input  1  system clock; all state changes on its rising edge.
- nResetIn  input  1  asynchronous, active-low reset.
- rxIn  input  1  filtered serial line, already synchronous to clkIn; idle = 1.
- enableIn  input  1  receiver enable; 0 aborts any frame in progress.
- readyIn  input  1  consumer accepts dataOut on an edge where validOut = 1 and readyIn = 1.
- dataOut  output  DATA_BITS  received byte held in the output buffer.
- validOut  output  1  output buffer holds an unconsumed byte.
- frameErrorOut  output  1  one-cycle pulse when the stop bit is sampled as 0.
- overrunOut  output  1  one-cycle pulse when a good frame is dropped because the buffer is full.
- busyOut  output  1  FSM is not IDLE (decoded from the state register).

## Operation
- Reset state: FSM = IDLE; cnt = 0; bitIdx = 0; shift register = 0; dataOut = 0; validOut = 0; frameErrorOut = 0; overrunOut = 0; busyOut = 0.
- Reset asserted mid-frame clears everything immediately. No partial byte is ever emitted.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: cnt = 0. If enableIn = 1 and rxIn = 0 at an edge, go to START with cnt = 0.
- START: at each edge, if cnt ≠ HALF−1 then cnt++. At cnt = HALF−1:
  - rxIn = 0: go to DATA with cnt = 0, bitIdx = 0.
  - rxIn = 1: glitch; return to IDLE silently.
- DATA: at each edge, if cnt ≠ CLKS_PER_BIT−1 then cnt++. At cnt = CLKS_PER_BIT−1:
  - shift = {rxIn, shift[DATA_BITS−1:1]} (LSB-first); cnt = 0; bitIdx++.
  - After the DATA_BITS-th sample, go to STOP.
- STOP: count the same way. At cnt = CLKS_PER_BIT−1, sample rxIn:
  - rxIn = 1 and (validOut = 0 or readyIn = 1): dataOut ← shift, validOut ← 1; go to IDLE.
  - rxIn = 1 and validOut = 1 and readyIn = 0: overrunOut pulses; the old dataOut is kept and the new byte is dropped; go to IDLE.
  - rxIn = 0: frameErrorOut pulses; the byte is discarded; go to WAIT_HIGH.
- WAIT_HIGH: stay until rxIn = 1 at an edge, then go to IDLE. This stops a break condition from being taken as a new start bit.
- enableIn = 0 at any edge forces the FSM to IDLE with cnt = 0 and no pulses. The output buffer and validOut are unaffected.
- Buffer:
  - validOut clears at an edge where validOut & readyIn and no new byte loads.
  - If a load and a consume occur at the same edge, the new byte wins and validOut stays 1.
- frameErrorOut and overrunOut each return to 0 on the edge after they assert.

## Timing
- E0 = the edge at which IDLE sees rxIn = 0.
- Start-bit check at E0+HALF.
- Data bit k (k = 0..DATA_BITS−1) sampled at E0+HALF+(k+1)·CLKS_PER_BIT.
- Stop bit sampled at Es = E0+HALF+(DATA_BITS+1)·CLKS_PER_BIT. dataOut, validOut, frameErrorOut and overrunOut update at Es, so they are visible in the cycle after Es.
- The FSM is IDLE after Es (good frame), so a start bit can be detected at Es+1. Back-to-back frames with no idle gap are supported.
- busyOut goes high in the cycle after E0 and low in the cycle after Es, or after the glitch/abort edge.
- For CLKS_PER_BIT = 16, DATA_BITS = 8: HALF = 8 and Es = E0+152.

## Test plan
All scenarios use CLKS_PER_BIT = 16 and DATA_BITS = 8.
- Good frame, readyIn = 1: frame 0x55 with stop = 1 → validOut = 1 and dataOut = 0x55 after E0+152; validOut drops one cycle later; no error pulses.
- Start glitch: rxIn low for 4 clocks, then high → FSM back to IDLE at E0+8; validOut never asserts; busyOut high for exactly 8 cycles.
- Frame error: 0xA3 with stop = 0, line held low for 40 more clocks → frameErrorOut one-cycle pulse at E0+152; validOut stays 0; no start detected until rxIn returns high, then a 0x3C frame is received correctly.
- Overrun: 0x12 then 0x34 back-to-back with readyIn = 0 → dataOut stays 0x12; overrunOut pulses at the second stop sample; raising readyIn consumes 0x12 and validOut clears.
- Abort and reset: enableIn = 0 during data bit 3 → IDLE with no output. nResetIn pulsed low during data bit 5 → all outputs 0 immediately. A following 0xC7 frame is received correctly.
- Load and consume at the same edge: validOut = 1 (0x11) and readyIn = 1 exactly at a new frame's Es (0x22) → dataOut = 0x22, validOut stays 1, overrunOut stays 0.

Source files
------------

// File: rtl/uart_rx_sequencer_if.sv
// Signal bundle between the UART receive sequencer and its surroundings:
// filtered serial line and enable in, byte buffer handshake and status out.
interface uart_rx_sequencer_if #(
  parameter int DATA_BITS = 8
);
  logic                 rxIn;
  logic                 enableIn;
  logic                 readyIn;
  logic [DATA_BITS-1:0] dataOut;
  logic                 validOut;
  logic                 frameErrorOut;
  logic                 overrunOut;
  logic                 busyOut;
  logic [2:0]           dbgStateOut;

  modport slave (
    input  rxIn, enableIn, readyIn,
    output dataOut, validOut, frameErrorOut, overrunOut, busyOut, dbgStateOut
  );

  modport master (
    output rxIn, enableIn, readyIn,
    input  dataOut, validOut, frameErrorOut, overrunOut, busyOut, dbgStateOut
  );
endinterface

// File: rtl/uart_rx_sequencer.sv
// Turns the filtered, idle-high RX stream into parallel bytes: start detect,
// mid-bit sampling LSB-first, stop check, one-entry output buffer.
module uart_rx_sequencer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input logic               clkIn,
  input logic               nResetIn,
  uart_rx_sequencer_if.slave bus
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  // Handshake: a byte is transferred on a rising edge where validOut and
  // readyIn are both 1; validOut stays high until then, and a byte loaded on
  // the same edge as a transfer replaces the consumed one.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;

    if (valid_q && bus.readyIn) begin
      valid_d = 1'b0;
    end

    if (!bus.enableIn) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (!bus.rxIn) begin
            state_d = S_START;
          end
        end
        S_START: begin
          if (cnt_q != HALF_M1) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d = '0;
            if (!bus.rxIn) begin
              state_d   = S_DATA;
              bit_idx_d = '0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (cnt_q != BIT_M1) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d     = '0;
            shift_d   = {bus.rxIn, shift_q[DATA_BITS-1:1]};
            bit_idx_d = bit_idx_q + IDX_ONE;
            if (bit_idx_q == LAST_IDX) begin
              state_d = S_STOP;
            end
          end
        end
        S_STOP: begin
          if (cnt_q != BIT_M1) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d = '0;
            if (bus.rxIn) begin
              state_d = S_IDLE;
              if (!valid_q || bus.readyIn) begin
                data_d  = shift_q;
                valid_d = 1'b1;
              end else begin
                ovr_d = 1'b1;
              end
            end else begin
              ferr_d  = 1'b1;
              state_d = S_WAIT_HIGH;
            end
          end
        end
        S_WAIT_HIGH: begin
          // A held-low line (break) must return high before a new start counts.
          if (bus.rxIn) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bus.dataOut       = data_q;
  assign bus.validOut      = valid_q;
  assign bus.frameErrorOut = ferr_q;
  assign bus.overrunOut    = ovr_q;
  assign bus.busyOut       = (state_q != S_IDLE);
  assign bus.dbgStateOut   = state_q;

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed bench for uart_rx_sequencer (16 clocks/bit, 8 data bits): a driver
// serialises frames, a monitor pops expected bytes on each consume.
module tb_uart_rx_sequencer;

  logic clkIn = 1'b0;
  logic nResetIn;

  always #5 clkIn = ~clkIn;

  uart_rx_sequencer_if #(.DATA_BITS(8)) bus ();

  uart_rx_sequencer #(
    .CLKS_PER_BIT(16),
    .DATA_BITS   (8)
  ) dut (
    .clkIn   (clkIn),
    .nResetIn(nResetIn),
    .bus     (bus)
  );

  logic [7:0] exp_q[$];
  int         checks    = 0;
  int         errors    = 0;
  int         ferr_seen = 0;
  int         ovr_seen  = 0;
  logic       prev_ferr = 1'b0;
  logic       prev_ovr  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every consumed byte must match the head of the expected queue.
  always @(negedge clkIn) begin
    if (nResetIn === 1'b1) begin
      if (bus.validOut && bus.readyIn) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL consume_unexpected: got 0x%0h expected no byte", bus.dataOut);
        end else begin
          check("consume_data", 32'(bus.dataOut), 32'(exp_q.pop_front()));
        end
      end
      if (bus.frameErrorOut) begin
        ferr_seen++;
        check("ferr_width", 32'(prev_ferr), 32'd0);
      end
      if (bus.overrunOut) begin
        ovr_seen++;
        check("ovr_width", 32'(prev_ovr), 32'd0);
      end
    end
    prev_ferr = bus.frameErrorOut;
    prev_ovr  = bus.overrunOut;
  end

  task automatic step();
    @(posedge clkIn);
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    bus.rxIn = v;
    repeat (n) step();
  endtask

  // Returns 1 time unit after the stop-sample edge Es (E0+152).
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic expect_byte, input logic ready_at_es);
    if (expect_byte) exp_q.push_back(d);
    drive(1'b0, 16);
    for (int k = 0; k < 8; k++) drive(d[k], 16);
    drive(stop, 8);
    if (ready_at_es) bus.readyIn = 1'b1;
    drive(stop, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   busy_cycles;
    logic valid_seen;
    logic [7:0] pat;

    nResetIn     = 1'b0;
    bus.rxIn     = 1'b1;
    bus.enableIn = 1'b1;
    bus.readyIn  = 1'b1;
    repeat (3) @(negedge clkIn);
    check("rst_valid", 32'(bus.validOut), 32'd0);
    check("rst_data",  32'(bus.dataOut),  32'd0);
    check("rst_busy",  32'(bus.busyOut),  32'd0);
    check("rst_ferr",  32'(bus.frameErrorOut), 32'd0);
    check("rst_ovr",   32'(bus.overrunOut), 32'd0);
    nResetIn = 1'b1;
    drive(1'b1, 4);

    // Good frame, consumer always ready
    send_frame(8'h55, 1'b1, 1'b1, 1'b0);
    @(negedge clkIn);
    check("good_valid", 32'(bus.validOut), 32'd1);
    check("good_data",  32'(bus.dataOut),  32'h55);
    check("good_ferr",  32'(bus.frameErrorOut), 32'd0);
    check("good_ovr",   32'(bus.overrunOut), 32'd0);
    @(negedge clkIn);
    check("good_valid_drop", 32'(bus.validOut), 32'd0);
    drive(1'b1, 8);

    // Start glitch: 4 low clocks
    busy_cycles = 0;
    valid_seen  = 1'b0;
    for (int i = 0; i < 24; i++) begin
      bus.rxIn = (i < 4) ? 1'b0 : 1'b1;
      @(posedge clkIn);
      @(negedge clkIn);
      if (bus.busyOut) busy_cycles++;
      if (bus.validOut) valid_seen = 1'b1;
    end
    check("glitch_busy_cycles", 32'(busy_cycles), 32'd8);
    check("glitch_valid", 32'(valid_seen), 32'd0);
    drive(1'b1, 4);

    // Frame error then break held low
    send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
    @(negedge clkIn);
    check("ferr_pulse", 32'(bus.frameErrorOut), 32'd1);
    check("ferr_valid", 32'(bus.validOut), 32'd0);
    @(negedge clkIn);
    check("ferr_clear", 32'(bus.frameErrorOut), 32'd0);
    drive(1'b0, 38);
    @(negedge clkIn);
    check("break_busy", 32'(bus.busyOut), 32'd1);
    check("break_valid", 32'(bus.validOut), 32'd0);
    drive(1'b1, 4);
    @(negedge clkIn);
    check("break_idle", 32'(bus.busyOut), 32'd0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 8);

    // Overrun: two back-to-back frames, consumer stalled
    bus.readyIn = 1'b0;
    send_frame(8'h12, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 7);
    send_frame(8'h34, 1'b1, 1'b0, 1'b0);
    @(negedge clkIn);
    check("ovr_pulse", 32'(bus.overrunOut), 32'd1);
    check("ovr_valid", 32'(bus.validOut), 32'd1);
    check("ovr_data_kept", 32'(bus.dataOut), 32'h12);
    @(negedge clkIn);
    check("ovr_clear", 32'(bus.overrunOut), 32'd0);
    step();
    bus.readyIn = 1'b1;
    drive(1'b1, 3);
    @(negedge clkIn);
    check("ovr_drained", 32'(bus.validOut), 32'd0);

    // Abort during data bit 3
    pat = 8'h96;
    drive(1'b0, 16);
    for (int k = 0; k < 3; k++) drive(pat[k], 16);
    drive(pat[3], 8);
    bus.enableIn = 1'b0;
    bus.rxIn     = 1'b1;
    step();
    @(negedge clkIn);
    check("abort_busy", 32'(bus.busyOut), 32'd0);
    check("abort_valid", 32'(bus.validOut), 32'd0);
    bus.enableIn = 1'b1;
    drive(1'b1, 20);
    @(negedge clkIn);
    check("abort_stays_idle", 32'(bus.busyOut), 32'd0);

    // Reset during data bit 5 with a byte waiting in the buffer
    bus.readyIn = 1'b0;
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 7);
    check("pre_rst_data", 32'(bus.dataOut), 32'h5A);
    pat = 8'hE1;
    drive(1'b0, 16);
    for (int k = 0; k < 5; k++) drive(pat[k], 16);
    drive(pat[5], 8);
    nResetIn = 1'b0;
    #2;
    check("midrst_valid", 32'(bus.validOut), 32'd0);
    check("midrst_data",  32'(bus.dataOut),  32'd0);
    check("midrst_busy",  32'(bus.busyOut),  32'd0);
    bus.rxIn = 1'b1;
    step();
    nResetIn    = 1'b1;
    bus.readyIn = 1'b1;
    drive(1'b1, 4);
    send_frame(8'hC7, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 8);

    // Load and consume on the same edge
    bus.readyIn = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 7);
    send_frame(8'h22, 1'b1, 1'b1, 1'b1);
    @(negedge clkIn);
    check("lc_valid", 32'(bus.validOut), 32'd1);
    check("lc_data",  32'(bus.dataOut),  32'h22);
    check("lc_ovr",   32'(bus.overrunOut), 32'd0);
    @(negedge clkIn);
    check("lc_drained", 32'(bus.validOut), 32'd0);
    drive(1'b1, 4);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("ferr_count",  32'(ferr_seen), 32'd1);
    check("ovr_count",   32'(ovr_seen),  32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
